// File: rtl/me_pkg.sv
// Shared types and constants for the integer motion-estimation search control.
//   SAD_W    : width of a SAD value from the 256-pixel adder tree
//   MV_W_MAX : container width of the signed MV fields in mv_t; instances
//              use a narrower MV_W derived from their search range
//   mv_t     : packed signed motion vector {mvx, mvy}
//   me_state_t : search FSM states
//   mv_width : signed component width needed for a search range of +/-sr
package me_pkg;

  localparam int SAD_W    = 16;
  localparam int MV_W_MAX = 8;

  typedef struct packed {
    logic signed [MV_W_MAX-1:0] mvx;
    logic signed [MV_W_MAX-1:0] mvy;
  } mv_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } me_state_t;

  function automatic int mv_width(input int sr);
    return $clog2(sr + 1) + 1;
  endfunction

endpackage

// File: rtl/sad_tag_pipe.sv
// Delay line that carries a {valid, mv} tag alongside the SAD datapath so
// each SAD leaving the adder tree can be matched to its candidate vector.
//   clk, rst  : clock, synchronous active-high reset (clears all tags)
//   in_valid  : candidate accepted this cycle (0 = bubble)
//   in_mv     : vector of the accepted candidate
//   out_valid : tag at the last stage is a real candidate
//   out_mv    : vector of that candidate
//   any_valid : some tag will still be in the line after the next edge
module sad_tag_pipe
  import me_pkg::*;
#(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  mv_t  in_mv,
  output logic out_valid,
  output mv_t  out_mv,
  output logic any_valid
);

  logic [DEPTH-1:0] valid_q, valid_d;
  mv_t              mv_q [DEPTH];
  mv_t              mv_d [DEPTH];

  // The adder tree has no enable, so the line shifts every cycle and a
  // stalled handshake simply inserts a bubble.
  always_comb begin
    valid_d[0] = in_valid;
    mv_d[0]    = in_mv;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      mv_d[i]    = mv_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) mv_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      mv_q    <= mv_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_mv    = mv_q[DEPTH-1];
  // Looking at the next-cycle contents lets the controller leave DRAIN in
  // the same cycle the final SAD is compared, so done lines up with it.
  assign any_valid = |valid_d;

endmodule

// File: rtl/sad_search_ctrl.sv
// Full-search integer motion-estimation controller. Issues every candidate
// vector in [-SR..+SR]^2 in raster order (mvx fastest), tracks each one
// through a tag line matched to the SAD tree latency, and keeps the first
// strictly smallest SAD.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a search (honoured only in IDLE)
//   busy              : high in ISSUE/DRAIN/DONE
//   cand_valid/ready  : candidate handshake to the fetch/abs-diff stage
//   cand_mvx/mvy      : signed candidate vector
//   sad_in            : SAD tree output, used only when a tag emerges
//   done              : one-cycle pulse, best_* valid
//   best_mvx/mvy/sad  : winning vector and its SAD
//   dbg_state         : current FSM state (me_state_t encoding)
//
// Handshake: a candidate transfers in any cycle where cand_valid and
// cand_ready are both high at the clock edge; cand_valid never drops and
// cand_mv* never change while a candidate is waiting for cand_ready.
module sad_search_ctrl
  import me_pkg::*;
#(
  parameter int SR       = 4,
  parameter int PIPE_LAT = 5,
  localparam int MV_W    = mv_width(SR)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   cand_valid,
  input  logic                   cand_ready,
  output logic signed [MV_W-1:0] cand_mvx,
  output logic signed [MV_W-1:0] cand_mvy,
  input  logic [SAD_W-1:0]       sad_in,
  output logic                   done,
  output logic signed [MV_W-1:0] best_mvx,
  output logic signed [MV_W-1:0] best_mvy,
  output logic [SAD_W-1:0]       best_sad,
  output logic [1:0]             dbg_state
);

  localparam logic signed [MV_W-1:0] MV_MIN = MV_W'(-SR);
  localparam logic signed [MV_W-1:0] MV_MAX = MV_W'(SR);
  localparam logic signed [MV_W-1:0] MV_ONE = MV_W'(1);

  me_state_t               state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    cand_valid_q, cand_valid_d;
  logic signed [MV_W-1:0]  mvx_q, mvx_d, mvy_q, mvy_d;
  logic                    done_q, done_d;
  logic signed [MV_W-1:0]  best_mvx_q, best_mvx_d, best_mvy_q, best_mvy_d;
  logic [SAD_W-1:0]        best_sad_q, best_sad_d;
  logic                    first_q, first_d;

  logic accept;
  logic last_cand;
  mv_t  pipe_in_mv;
  logic pipe_out_valid;
  mv_t  pipe_out_mv;
  logic pipe_any_valid;
  logic unused_pipe_mv;

  assign accept    = cand_valid_q & cand_ready;
  assign last_cand = (mvx_q == MV_MAX) && (mvy_q == MV_MAX);

  assign pipe_in_mv.mvx = MV_W_MAX'(mvx_q);
  assign pipe_in_mv.mvy = MV_W_MAX'(mvy_q);

  sad_tag_pipe #(
    .DEPTH(PIPE_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .in_mv    (pipe_in_mv),
    .out_valid(pipe_out_valid),
    .out_mv   (pipe_out_mv),
    .any_valid(pipe_any_valid)
  );

  // Only the low MV_W bits of the sign-extended tag are meaningful.
  assign unused_pipe_mv = ^pipe_out_mv;

  always_comb begin
    state_d    = state_q;
    mvx_d      = mvx_q;
    mvy_d      = mvy_q;
    best_mvx_d = best_mvx_q;
    best_mvy_d = best_mvy_q;
    best_sad_d = best_sad_q;
    first_d    = first_q;

    // First real result always loads, so an all-ones SAD can still win.
    // Strict compare keeps the earlier raster candidate on a tie.
    if (pipe_out_valid && (first_q || (sad_in < best_sad_q))) begin
      best_mvx_d = pipe_out_mv.mvx[MV_W-1:0];
      best_mvy_d = pipe_out_mv.mvy[MV_W-1:0];
      best_sad_d = sad_in;
      first_d    = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ISSUE;
          mvx_d      = MV_MIN;
          mvy_d      = MV_MIN;
          best_mvx_d = '0;
          best_mvy_d = '0;
          best_sad_d = '1;
          first_d    = 1'b1;
        end
      end
      ISSUE: begin
        if (accept) begin
          if (last_cand) begin
            state_d = DRAIN;
          end else if (mvx_q == MV_MAX) begin
            mvx_d = MV_MIN;
            mvy_d = mvy_q + MV_ONE;
          end else begin
            mvx_d = mvx_q + MV_ONE;
          end
        end
      end
      DRAIN: begin
        if (!pipe_any_valid) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d       = (state_d != IDLE);
    cand_valid_d = (state_d == ISSUE);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      cand_valid_q <= 1'b0;
      mvx_q        <= '0;
      mvy_q        <= '0;
      done_q       <= 1'b0;
      best_mvx_q   <= '0;
      best_mvy_q   <= '0;
      best_sad_q   <= '0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      cand_valid_q <= cand_valid_d;
      mvx_q        <= mvx_d;
      mvy_q        <= mvy_d;
      done_q       <= done_d;
      best_mvx_q   <= best_mvx_d;
      best_mvy_q   <= best_mvy_d;
      best_sad_q   <= best_sad_d;
      first_q      <= first_d;
    end
  end

  assign busy       = busy_q;
  assign cand_valid = cand_valid_q;
  assign cand_mvx   = mvx_q;
  assign cand_mvy   = mvy_q;
  assign done       = done_q;
  assign best_mvx   = best_mvx_q;
  assign best_mvy   = best_mvy_q;
  assign best_sad   = best_sad_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
module tb_sad_search_ctrl;

  localparam int SR       = 1;
  localparam int PIPE_LAT = 5;
  localparam int MV_W     = 2;
  localparam int NCAND    = 9;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start;
  logic              busy;
  logic              cand_valid;
  logic              cand_ready;
  logic [MV_W-1:0]   cand_mvx;
  logic [MV_W-1:0]   cand_mvy;
  logic [15:0]       sad_in;
  logic              done;
  logic [MV_W-1:0]   best_mvx;
  logic [MV_W-1:0]   best_mvy;
  logic [15:0]       best_sad;
  logic [1:0]        dbg_state;

  sad_search_ctrl #(
    .SR      (SR),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .cand_valid(cand_valid),
    .cand_ready(cand_ready),
    .cand_mvx  (cand_mvx),
    .cand_mvy  (cand_mvy),
    .sad_in    (sad_in),
    .done      (done),
    .best_mvx  (best_mvx),
    .best_mvy  (best_mvy),
    .best_sad  (best_sad),
    .dbg_state (dbg_state)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  int cyc;
  logic [2*MV_W-1:0] exp_q[$];
  int                res_cyc_q[$];
  logic [15:0]       res_sad_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // mode 0: 100 except (+1,0)=20; mode 1: all 50; mode 2: all 16'hFFFF
  function automatic logic [15:0] sad_of(input int mode, input logic [1:0] x, input logic [1:0] y);
    if (mode == 0) return (x == 2'b01 && y == 2'b00) ? 16'd20 : 16'd100;
    if (mode == 1) return 16'd50;
    return 16'hFFFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present the SAD belonging to a tag due this cycle; otherwise drive a
  // small junk value that would win if a bubble were ever compared.
  task automatic drive_sad();
    sad_in = 16'h0001;
    if (res_cyc_q.size() > 0 && res_cyc_q[0] == cyc) begin
      sad_in = res_sad_q[0];
      void'(res_cyc_q.pop_front());
      void'(res_sad_q.pop_front());
    end
  endtask

  // ready_mode 0: always ready; 1: ready on odd cycles only.
  // rst_after > 0: reset right after that many accepts.
  task automatic run_search(input int sad_mode, input int ready_mode, input int rst_after,
                            input int poke_start, input logic [1:0] ex, input logic [1:0] ey,
                            input logic [15:0] es, input int exp_done_cyc);
    int accepts;
    int done_cyc;
    int extra;
    int busy_seen;
    exp_q.delete();
    res_cyc_q.delete();
    res_sad_q.delete();
    for (int y = -1; y <= 1; y++)
      for (int x = -1; x <= 1; x++)
        exp_q.push_back({2'(x), 2'(y)});
    accepts  = 0;
    done_cyc = -1;
    cyc      = 0;
    start    = 1'b1;
    cand_ready = 1'b1;
    sad_in   = 16'h0001;
    for (int n = 0; n < 80; n++) begin
      tick();
      start = (poke_start != 0 && cyc == 3) ? 1'b1 : 1'b0;
      cand_ready = (ready_mode == 0) ? 1'b1 : 1'(cyc % 2);
      drive_sad();
      if (cyc == 1) begin
        check_eq("busy_issue", 32'(busy), 32'd1);
        check_eq("cand_valid_issue", 32'(cand_valid), 32'd1);
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (cand_valid && cand_ready) begin
        accepts++;
        if (exp_q.size() == 0) check_eq("extra_accept", 32'(accepts), 32'(NCAND));
        else check_eq("mv_order", 32'({cand_mvx, cand_mvy}), 32'(exp_q.pop_front()));
        res_cyc_q.push_back(cyc + PIPE_LAT);
        res_sad_q.push_back(sad_of(sad_mode, cand_mvx, cand_mvy));
        if (rst_after > 0 && accepts == rst_after) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          start = 1'b0;
          check_eq("rst_busy", 32'(busy), 32'd0);
          check_eq("rst_cand_valid", 32'(cand_valid), 32'd0);
          check_eq("rst_done", 32'(done), 32'd0);
          check_eq("rst_cand_mv", 32'({cand_mvx, cand_mvy}), 32'd0);
          check_eq("rst_best", 32'({best_mvx, best_mvy, best_sad}), 32'd0);
          check_eq("rst_state", 32'(dbg_state), 32'd0);
          extra = 0;
          busy_seen = 0;
          for (int k = 0; k < 12; k++) begin
            tick();
            sad_in = 16'd0;
            if (done) extra++;
            if (busy) busy_seen++;
          end
          check_eq("rst_no_done", 32'(extra), 32'd0);
          check_eq("rst_stays_idle", 32'(busy_seen), 32'd0);
          return;
        end
      end
    end
    if (done_cyc < 0) begin
      check_eq("done_timeout", 32'd0, 32'd1);
      return;
    end
    check_eq("done_cycle", 32'(done_cyc), 32'(exp_done_cyc));
    check_eq("accept_count", 32'(accepts), 32'(NCAND));
    check_eq("all_cands_issued", 32'(exp_q.size()), 32'd0);
    check_eq("best_mvx", 32'(best_mvx), 32'(ex));
    check_eq("best_mvy", 32'(best_mvy), 32'(ey));
    check_eq("best_sad", 32'(best_sad), 32'(es));
    // start during DONE must be ignored
    if (poke_start != 0) start = 1'b1;
    extra = 0;
    busy_seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      start  = 1'b0;
      sad_in = 16'h0001;
      if (done) extra++;
      if (busy) busy_seen++;
    end
    check_eq("done_single_pulse", 32'(extra), 32'd0);
    check_eq("idle_after_done", 32'(busy_seen), 32'd0);
    check_eq("best_hold", 32'({best_mvx, best_mvy, best_sad}), 32'({ex, ey, es}));
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    cand_ready = 1'b0;
    sad_in     = 16'd0;
    cyc        = 0;
    repeat (3) tick();
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_cand_valid", 32'(cand_valid), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_outputs", 32'({cand_mvx, cand_mvy, best_mvx, best_mvy, best_sad}), 32'd0);
    rst = 1'b0;
    tick();

    // 1: single minimum at (+1,0)
    run_search(0, 0, 0, 0, 2'b01, 2'b00, 16'd20, 15);
    // 2: all ties, first raster candidate wins
    run_search(1, 0, 0, 0, 2'b11, 2'b11, 16'd50, 15);
    // 3: alternating ready, accepts at cycles 1,3,..,17 -> done at 17+5+1
    run_search(0, 1, 0, 0, 2'b01, 2'b00, 16'd20, 23);
    // 4: all-ones SAD still loads via first result
    run_search(2, 0, 0, 0, 2'b11, 2'b11, 16'hFFFF, 15);
    // 5: start pokes during ISSUE and DONE are ignored
    run_search(0, 0, 0, 1, 2'b01, 2'b00, 16'd20, 15);
    // 6: reset after 4 accepts, then a clean search
    run_search(0, 0, 4, 0, 2'b00, 2'b00, 16'd0, 0);
    run_search(0, 0, 0, 0, 2'b01, 2'b00, 16'd20, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
